// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and occupancy width helper for pipe_stage_chain
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Enough bits to count every stage plus the optional skid slot without wrapping.
    function automatic int occ_width(input int depth, input int skid);
        return $clog2(depth + skid + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid/payload register with load and clear
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic             next_v,
    input  logic [WIDTH-1:0] next_d,
    output logic             v,
    output logic             v_nxt,
    output logic [WIDTH-1:0] d
);

    logic             v_d, v_q;
    logic [WIDTH-1:0] d_d, d_q;

    // Clear wins over load so a killed slot always reads back as an all-zero bubble.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (load) begin
            v_d = next_v;
            d_d = next_d;
        end
        if (clear) begin
            v_d = 1'b0;
            d_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v     = v_q;
    assign v_nxt = v_d;
    assign d     = d_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - pipeline register chain with valid/ready, bubbles, per-stage kill and optional skid
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SKID  = 0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     out_data,
    input  logic [DEPTH-1:0]                     flush,
    output logic [occ_width(DEPTH, SKID)-1:0]    occupancy
);

    localparam int OW = occ_width(DEPTH, SKID);

    logic [DEPTH-1:0] v, v_nxt, load;
    logic [WIDTH-1:0] d [DEPTH];
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic             skid_nxt;
    logic [OW-1:0]    occ_d, occ_q;

    // A stage can load when it is empty or its item moves on; walk from the tail.
    always_comb begin
        logic nxt_load;
        nxt_load = out_ready;
        load     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            load[i]  = !v[i] | nxt_load;
            nxt_load = load[i];
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic             skid_v, skid_v_nxt;
            logic [WIDTH-1:0] skid_d;

            pipe_slot #(.WIDTH(WIDTH)) u_skid (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (load[0] | !skid_v),
                .clear   (flush[0]),
                .next_v  (in_valid & !skid_v & !load[0]),
                .next_d  (in_data),
                .v       (skid_v),
                .v_nxt   (skid_v_nxt),
                .d       (skid_d)
            );

            assign in_ready = !skid_v;
            assign src_v    = skid_v | in_valid;
            assign src_d    = skid_v ? skid_d : in_data;
            assign skid_nxt = skid_v_nxt;
        end else begin : g_noskid
            assign in_ready = load[0];
            assign src_v    = in_valid;
            assign src_d    = in_data;
            assign skid_nxt = 1'b0;
        end
    endgenerate

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             nv;
            logic [WIDTH-1:0] nd;
            if (i == 0) begin : g_head
                assign nv = src_v;
                assign nd = src_d;
            end else begin : g_body
                assign nv = v[i-1];
                assign nd = d[i-1];
            end

            pipe_slot #(.WIDTH(WIDTH)) u_slot (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (load[i]),
                .clear   (flush[i]),
                .next_v  (nv),
                .next_d  (nd),
                .v       (v[i]),
                .v_nxt   (v_nxt[i]),
                .d       (d[i])
            );
        end
    endgenerate

    // Count from next-state flags so accept, drain and kill in one edge net out exactly.
    always_comb begin
        occ_d = OW'(skid_nxt);
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OW'(v_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ_q;

endmodule
